// File: rtl/uart_echo_tester_if.sv
// Byte-stream bundle between the echo tester and a UART.
//   output_axis_*  : bytes from the tester to the UART transmitter
//   input_axis_*   : bytes from the UART receiver back to the tester
// The master modport is the tester side. The slave modport is the UART side.
interface uart_echo_tester_if;
  logic [7:0] output_axis_tdata;
  logic       output_axis_tvalid;
  logic       output_axis_tready;
  logic [7:0] input_axis_tdata;
  logic       input_axis_tvalid;
  logic       input_axis_tready;

  modport master (
    output output_axis_tdata,
    output output_axis_tvalid,
    input  output_axis_tready,
    input  input_axis_tdata,
    input  input_axis_tvalid,
    output input_axis_tready
  );

  modport slave (
    input  output_axis_tdata,
    input  output_axis_tvalid,
    output output_axis_tready,
    output input_axis_tdata,
    output input_axis_tvalid,
    input  input_axis_tready
  );
endinterface

// File: rtl/uart_echo_tester.sv
// UART echo-loop initiator.
// It sends the byte sequence seed, seed+1, ... (mod 256) on the transmit
// stream and checks each echoed byte on the receive stream against the
// same sequence. At most MAX_OUTSTANDING bytes may be unanswered at any
// time. If TIMEOUT cycles pass with bytes outstanding and no echo, the
// test is aborted.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a test; accepted in IDLE or DONE
//   count, seed    byte count and first byte value, latched on start
//   axis           master side of the transmit and receive byte streams
//   busy, done     test running / test finished (level)
//   pass           finished with no errors and no timeout
//   timeout_error  test aborted because an echo was lost
//   tx_count       bytes sent in this test
//   rx_count       echoes received in this test
//   error_count    mismatched or unexpected bytes; saturates at all-ones
module uart_echo_tester #(
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic [7:0]           seed,
  uart_echo_tester_if.master   axis,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout_error,
  output logic [CNT_WIDTH-1:0] tx_count,
  output logic [CNT_WIDTH-1:0] rx_count,
  output logic [CNT_WIDTH-1:0] error_count
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [7:0]           seed_q, seed_d;
  logic [CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic                 tmo_err_q, tmo_err_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 tvalid_q, tvalid_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  logic                 tx_fire;
  logic                 rx_fire;
  logic [CNT_WIDTH-1:0] outstanding;
  logic [CNT_WIDTH-1:0] err_inc;
  logic [7:0]           exp_rx;
  logic [TMO_W-1:0]     tmo_inc;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    seed_d    = seed_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    err_d     = err_q;
    tmo_err_d = tmo_err_q;
    tmo_cnt_d = tmo_cnt_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;

    tx_fire     = tvalid_q && axis.output_axis_tready;
    // The receive side is always ready, so a valid byte is a transfer.
    rx_fire     = axis.input_axis_tvalid;
    outstanding = tx_cnt_q - rx_cnt_q;
    err_inc     = (err_q == '1) ? err_q : err_q + 1'b1;
    exp_rx      = seed_q + rx_cnt_q[7:0];
    tmo_inc     = tmo_cnt_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          count_d   = count;
          seed_d    = seed;
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          err_d     = '0;
          tmo_err_d = 1'b0;
          tmo_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (tx_fire) tx_cnt_d = tx_cnt_q + 1'b1;
        if (rx_fire) begin
          if (outstanding != '0) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
            if (axis.input_axis_tdata != exp_rx) err_d = err_inc;
          end else begin
            err_d = err_inc;
          end
        end
        if (rx_fire || outstanding == '0) tmo_cnt_d = '0;
        else                              tmo_cnt_d = tmo_inc;
        if (tx_cnt_q == count_q && rx_cnt_q == count_q) begin
          state_d = S_DONE;
        end else if (!rx_fire && outstanding != '0 && tmo_inc == TMO_W'(TIMEOUT)) begin
          state_d   = S_DONE;
          tmo_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The next counts are used so the window refills back-to-back. A byte
    // already offered is held until accepted, unless the test ends first.
    if (state_d != S_RUN) begin
      tvalid_d = 1'b0;
    end else if (tvalid_q && !axis.output_axis_tready) begin
      tvalid_d = 1'b1;
    end else if (state_q == S_RUN && tx_cnt_d < count_q &&
                 (tx_cnt_d - rx_cnt_d) < CNT_WIDTH'(MAX_OUTSTANDING)) begin
      tvalid_d = 1'b1;
      tdata_d  = seed_q + tx_cnt_d[7:0];
    end else begin
      tvalid_d = 1'b0;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0) && !tmo_err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      seed_q    <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_q     <= '0;
      tmo_err_q <= 1'b0;
      tmo_cnt_q <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      seed_q    <= seed_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_q     <= err_d;
      tmo_err_q <= tmo_err_d;
      tmo_cnt_q <= tmo_cnt_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign axis.output_axis_tdata  = tdata_q;
  assign axis.output_axis_tvalid = tvalid_q;
  assign axis.input_axis_tready  = 1'b1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout_error = tmo_err_q;
  assign tx_count      = tx_cnt_q;
  assign rx_count      = rx_cnt_q;
  assign error_count   = err_q;
endmodule

// File: tb/tb_uart_echo_tester.sv
`timescale 1ns/1ps
module tb_uart_echo_tester;
  localparam int CW  = 16;
  localparam int MO  = 4;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] count;
  logic [7:0]    seed;
  logic          busy, done, pass, timeout_error;
  logic [CW-1:0] tx_count, rx_count, error_count;

  int total = 0;
  int bad   = 0;

  uart_echo_tester_if axis();

  uart_echo_tester #(.CNT_WIDTH(CW), .MAX_OUTSTANDING(MO), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .count         (count),
    .seed          (seed),
    .axis          (axis),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout_error (timeout_error),
    .tx_count      (tx_count),
    .rx_count      (rx_count),
    .error_count   (error_count)
  );

  always #5 clk = ~clk;

  // Controls written only by the main sequence.
  int         test_id    = 0;
  int         stray_id   = 0;
  logic [7:0] stray_data = 8'h00;
  logic [7:0] exp_seed   = 8'h00;
  bit         echo_en    = 1'b1;
  bit         rand_ready = 1'b0;
  bit         tready_hold = 1'b0;
  int         max_delay  = 0;
  bit         corrupt [0:255];
  bit         drop    [0:255];

  // State written only by the UART/echo model.
  typedef struct { logic [7:0] data; int due; } echo_t;
  echo_t  q[$];
  int     cyc        = 0;
  int     tx_idx     = 0;
  int     tx_fires   = 0;
  int     tx_seq_err = 0;
  int     last_test  = 0;
  int     last_stray = 0;
  longint last_rx_t  = 0;

  // UART model: accepts transmitted bytes, scores them against seed+n, and
  // echoes them after a delay, optionally corrupted or dropped.
  initial begin
    echo_t      ent;
    logic [7:0] exp_b;
    axis.output_axis_tready = 1'b1;
    axis.input_axis_tvalid  = 1'b0;
    axis.input_axis_tdata   = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (test_id != last_test) begin
        last_test = test_id;
        q.delete();
        tx_idx = 0;
      end
      if (tready_hold)     axis.output_axis_tready = 1'b0;
      else if (rand_ready) axis.output_axis_tready = ($urandom_range(0, 3) != 0);
      else                 axis.output_axis_tready = 1'b1;
      if (!rst && axis.output_axis_tvalid && axis.output_axis_tready) begin
        exp_b = exp_seed + 8'(tx_idx);
        if (axis.output_axis_tdata !== exp_b) tx_seq_err++;
        tx_fires++;
        if (!drop[tx_idx]) begin
          ent.data = axis.output_axis_tdata ^ {7'd0, corrupt[tx_idx]};
          ent.due  = cyc + 1 + int'($urandom_range(0, max_delay));
          q.push_back(ent);
        end
        tx_idx++;
      end
      if (stray_id != last_stray) begin
        last_stray = stray_id;
        axis.input_axis_tvalid = 1'b1;
        axis.input_axis_tdata  = stray_data;
      end else if (echo_en && q.size() != 0 && q[0].due <= cyc) begin
        ent = q.pop_front();
        axis.input_axis_tvalid = 1'b1;
        axis.input_axis_tdata  = ent.data;
        last_rx_t = longint'($time) + 5;
      end else begin
        axis.input_axis_tvalid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_faults();
    for (int k = 0; k < 256; k++) begin
      corrupt[k] = 1'b0;
      drop[k]    = 1'b0;
    end
  endtask

  task automatic start_test(input logic [7:0] s, input int n);
    test_id++;
    exp_seed = s;
    tick(1);
    seed  = s;
    count = CW'(n);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output longint done_t);
    lat = 0;
    while (!done && lat < 3000) begin
      tick(1);
      lat++;
    end
    done_t = longint'($time) - 1;
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_end(input string tag, input logic ep, input int ee,
                           input int et, input int er, input logic eto);
    check({tag, ".done"},    32'(done), 32'd1);
    check({tag, ".busy"},    32'(busy), 32'd0);
    check({tag, ".pass"},    32'(pass), 32'(ep));
    check({tag, ".timeout"}, 32'(timeout_error), 32'(eto));
    check({tag, ".errors"},  32'(error_count), 32'(ee));
    check({tag, ".tx"},      32'(tx_count), 32'(et));
    check({tag, ".rx"},      32'(rx_count), 32'(er));
    check({tag, ".tx_seq"},  32'(tx_seq_err), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".busy"},    32'(busy), 32'd0);
    check({tag, ".done"},    32'(done), 32'd0);
    check({tag, ".pass"},    32'(pass), 32'd0);
    check({tag, ".timeout"}, 32'(timeout_error), 32'd0);
    check({tag, ".tx"},      32'(tx_count), 32'd0);
    check({tag, ".rx"},      32'(rx_count), 32'd0);
    check({tag, ".errors"},  32'(error_count), 32'd0);
    check({tag, ".tvalid"},  32'(axis.output_axis_tvalid), 32'd0);
    check({tag, ".tdata"},   32'(axis.output_axis_tdata), 32'd0);
    check({tag, ".rready"},  32'(axis.input_axis_tready), 32'd1);
  endtask

  typedef struct {
    logic [7:0] s;
    int         n;
    int         bad_idx;
    logic       exp_pass;
    int         exp_err;
    int         exp_tx;
    int         exp_rx;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    int          lat;
    longint      done_t;
    int          f0;
    logic [7:0]  s;
    int          n;
    int          errs;
    logic [7:0]  got [$];

    vecs[0] = '{8'hFE, 5, -1, 1'b1, 0, 5, 5};
    vecs[1] = '{8'h10, 4,  2, 1'b0, 1, 4, 4};
    vecs[2] = '{8'h7F, 1,  0, 1'b0, 1, 1, 1};
    vecs[3] = '{8'h33, 0, -1, 1'b1, 0, 0, 0};
    vecs[4] = '{8'hF0, 20, -1, 1'b1, 0, 20, 20};

    clear_faults();
    rst   = 1'b1;
    start = 1'b0;
    count = '0;
    seed  = '0;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(2);

    stray_data = 8'h5A;
    stray_id++;
    tick(4);
    check("idle_stray.errors", 32'(error_count), 32'd0);
    check("idle_stray.busy",   32'(busy), 32'd0);
    check("idle_stray.done",   32'(done), 32'd0);

    for (int v = 0; v < 5; v++) begin
      clear_faults();
      if (vecs[v].bad_idx >= 0) corrupt[vecs[v].bad_idx] = 1'b1;
      f0 = tx_fires;
      start_test(vecs[v].s, vecs[v].n);
      wait_done(lat, done_t);
      check_end($sformatf("vec%0d", v), vecs[v].exp_pass, vecs[v].exp_err,
                vecs[v].exp_tx, vecs[v].exp_rx, 1'b0);
      check($sformatf("vec%0d.fires", v), 32'(tx_fires - f0), 32'(vecs[v].exp_tx));
      if (vecs[v].n == 0) check("cnt0.latency_le2", 32'(lat <= 2), 32'd1);
    end

    // Window: no echoes, so exactly MO bytes go out and then tvalid stays low.
    clear_faults();
    echo_en = 1'b0;
    f0 = tx_fires;
    start_test(8'h40, 8);
    tick(30);
    check("window.fires",  32'(tx_fires - f0), 32'(MO));
    check("window.tvalid", 32'(axis.output_axis_tvalid), 32'd0);
    check("window.tx",     32'(tx_count), 32'(MO));
    check("window.rx",     32'(rx_count), 32'd0);
    check("window.busy",   32'(busy), 32'd1);
    echo_en = 1'b1;
    wait_done(lat, done_t);
    check_end("window_end", 1'b1, 0, 8, 8, 1'b0);

    // Stray byte in RUN with nothing outstanding, then a start while busy.
    clear_faults();
    tready_hold = 1'b1;
    start_test(8'h22, 2);
    tick(3);
    stray_data = 8'h22;
    stray_id++;
    tick(3);
    check("run_stray.errors", 32'(error_count), 32'd1);
    check("run_stray.rx",     32'(rx_count), 32'd0);
    check("run_stray.busy",   32'(busy), 32'd1);
    seed  = 8'h99;
    count = CW'(7);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check("busy_start.busy",   32'(busy), 32'd1);
    check("busy_start.errors", 32'(error_count), 32'd1);
    check("busy_start.tx",     32'(tx_count), 32'd0);
    tready_hold = 1'b0;
    wait_done(lat, done_t);
    check_end("busy_start_end", 1'b0, 1, 2, 2, 1'b0);

    // Lost echo: byte 3 of 6 never returns. Later echoes are compared by
    // arrival order against the expected sequence.
    clear_faults();
    drop[3] = 1'b1;
    s = 8'hC0;
    n = 6;
    got.delete();
    for (int k = 0; k < n; k++) if (!drop[k]) got.push_back(s + 8'(k));
    errs = 0;
    for (int j = 0; j < got.size(); j++) if (got[j] != s + 8'(j)) errs++;
    start_test(s, n);
    wait_done(lat, done_t);
    check_end("lost", 1'b0, errs, n, got.size(), 1'b1);
    check("lost.timeout_cycles", 32'((done_t - last_rx_t) / 10), 32'(TMO));

    // Reset in the middle of a run.
    clear_faults();
    start_test(8'h01, 30);
    tick(5);
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    check_reset_vals("midrst");
    rst = 1'b0;
    tick(2);

    // Random: random seed/count, backpressure, echo delay and corruption.
    rand_ready = 1'b1;
    for (int it = 0; it < 15; it++) begin
      clear_faults();
      s = 8'($urandom);
      n = int'($urandom_range(1, 40));
      max_delay = int'($urandom_range(0, 3));
      errs = 0;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          corrupt[k] = 1'b1;
          errs++;
        end
      end
      start_test(s, n);
      wait_done(lat, done_t);
      check_end($sformatf("rand%0d", it), (errs == 0), errs, n, n, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
